dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: data-memory word address width.
REQ-002 Parameter DATA_W, default 16: data-memory word width.
REQ-003 Parameter STARVE_LIMIT, default 4: maximum consecutive cycles an eligible debug request may lose to the CPU; legal range 1..15.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 cpu_req  in  1  CPU requests a data-memory access this cycle.
REQ-007 cpu_we  in  1  CPU access is a write.
REQ-008 cpu_addr  in  ADDR_W  CPU word address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_rdata  out  DATA_W  CPU read data.
REQ-011 cpu_stall  out  1  CPU access not granted this cycle; CPU holds its request.
REQ-012 dbg_req  in  1  debug/loader port requests an access; level, held until dbg_ack.
REQ-013 dbg_we  in  1  debug access is a write.
REQ-014 dbg_addr  in  ADDR_W  debug word address.
REQ-015 dbg_wdata  in  DATA_W  debug write data.
REQ-016 dbg_ack  out  1  one-cycle pulse: debug access complete.
REQ-017 dbg_rdata  out  DATA_W  registered debug read data.
REQ-018 mem_en  out  1  memory access enable.
REQ-019 mem_we  out  1  memory write enable.
REQ-020 mem_addr  out  ADDR_W  memory address.
REQ-021 mem_wdata  out  DATA_W  memory write data.
REQ-022 mem_rdata  in  DATA_W  memory read data; synchronous read, valid the cycle after the access.

Function
REQ-023 The block SHALL issue at most one memory access per cycle, to either the CPU or the debug port, driving mem_* combinationally from the granted port's inputs.
REQ-024 The debug port SHALL use a two-state FSM: D_IDLE, in which dbg_req is eligible, and D_ACK, in which it is not.
REQ-025 Grant: debug eligible and cpu_req low -> debug; both requesting and starve_cnt < STARVE_LIMIT -> CPU; both requesting and starve_cnt == STARVE_LIMIT -> debug; neither requesting -> mem_en low.
REQ-026 starve_cnt SHALL increment in each cycle the debug port is eligible but not granted, SHALL saturate at STARVE_LIMIT, and SHALL clear on a debug grant.
REQ-027 cpu_stall SHALL equal cpu_req AND NOT CPU-granted, combinationally; it is never asserted while cpu_req is low.
REQ-028 cpu_rdata SHALL pass mem_rdata through; it is valid the cycle after a granted CPU read and undefined otherwise.
REQ-029 A debug grant SHALL move the FSM D_IDLE -> D_ACK; the next cycle dbg_ack=1 and the FSM returns D_ACK -> D_IDLE.
REQ-030 For a debug read, dbg_rdata SHALL capture mem_rdata in the D_ACK cycle and hold it until the next debug read completes; a debug write SHALL leave dbg_rdata unchanged.
REQ-031 dbg_req seen in the D_ACK cycle SHALL be ignored; a new debug transaction becomes eligible the cycle after dbg_ack, giving at most one debug access per 2 cycles.
REQ-032 Write-then-read to the same address on alternate ports SHALL complete in grant order, with the read returning the written value.
REQ-033 If dbg_req drops before grant, the block SHALL make no access, send no ack, and clear starve_cnt.

Reset
REQ-034 While rst=1: mem_en=0, mem_we=0, cpu_stall=0, dbg_ack=0, dbg_rdata=0, starve_cnt=0, FSM=D_IDLE.
REQ-035 Reset asserted in D_ACK SHALL suppress the pending dbg_ack; the interrupted debug access is not retried.
REQ-036 In the first cycle after rst falls, requests SHALL be arbitrated normally.

Verification
REQ-037 CPU only, write 0x1234 to addr 3, then read addr 3 -> cpu_stall never high; cpu_rdata=0x1234 one cycle after the read.
REQ-038 Debug only, write 0xBEEF to addr 0, then read addr 0 -> each dbg_ack a single-cycle pulse 1 cycle after grant; dbg_rdata=0xBEEF.
REQ-039 cpu_req held high continuously, dbg_req raised with STARVE_LIMIT=4 -> debug granted on the 5th eligible cycle; cpu_stall high exactly that cycle.
REQ-040 Debug read pending, rst pulsed in the D_ACK cycle -> no dbg_ack; dbg_rdata=0; mem_en=0 during reset.
REQ-041 dbg_req held high across ack -> accesses spaced 2 cycles apart; no access issued in any D_ACK cycle.
REQ-042 Loader fills addr 0..1 via debug, CPU program writes addr 2 -> memory contents at addr 2 equal (addr0+addr1) mod 2^16 for 64 random operand pairs.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous-read memory port between the CPU and a
// debug/loader port, with a starvation bound on how long the debug port can be held off.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dbg_state
);

    // Handshake: the debug side holds dbg_req (and its command) level until it sees
    // dbg_ack, a single-cycle pulse the cycle after its grant; the CPU holds cpu_req
    // while cpu_stall is high. A request is consumed only in a granted cycle.
    typedef enum logic {
        D_IDLE = 1'b0,
        D_ACK  = 1'b1
    } dstate_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    dstate_t           state;
    logic [3:0]        starve_cnt;
    logic              rd_pend;
    logic [DATA_W-1:0] rdata_q;
    logic              dbg_elig;
    logic              dbg_gnt;
    logic              cpu_gnt;

    always_comb begin
        dbg_elig = !rst && (state == D_IDLE) && dbg_req;
        dbg_gnt  = dbg_elig && (!cpu_req || (starve_cnt >= LIMIT));
        cpu_gnt  = !rst && cpu_req && !dbg_gnt;
    end

    always_comb begin
        mem_en    = dbg_gnt || cpu_gnt;
        mem_we    = dbg_gnt ? dbg_we    : (cpu_gnt && cpu_we);
        mem_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
        mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    end

    assign cpu_stall = !rst && cpu_req && !cpu_gnt;
    assign cpu_rdata = mem_rdata;
    // Gated by rst so a reset landing in the ack cycle swallows the pulse immediately.
    assign dbg_ack   = !rst && (state == D_ACK);
    assign dbg_rdata = rst ? '0 : rdata_q;
    assign dbg_state = (state == D_ACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= D_IDLE;
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state)
                D_IDLE: begin
                    if (dbg_gnt) begin
                        state   <= D_ACK;
                        rd_pend <= !dbg_we;
                    end
                end
                D_ACK: begin
                    state <= D_IDLE;
                    if (rd_pend) begin
                        rdata_q <= mem_rdata;
                    end
                end
                default: state <= D_IDLE;
            endcase

            // A withdrawn or completed debug request restarts the starvation window.
            if (dbg_elig && !dbg_gnt) begin
                if (starve_cnt < LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural synchronous-read memory sits on the
// mem_* port and every step checks the arbiter outputs against hand-derived values.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        dbg_state;

    logic [15:0] mem_model [0:255];

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_arbiter #(
        .ADDR_W(8),
        .DATA_W(16),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dbg_req(dbg_req),
        .dbg_we(dbg_we),
        .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack),
        .dbg_rdata(dbg_rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read memory seen by the arbiter.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    // Presents one cycle of inputs just after a rising edge, then settles so both the
    // combinational outputs for this cycle and the registered ones are stable.
    task automatic drive(input logic r,
                         input logic c_req, input logic c_we,
                         input logic [7:0] c_addr, input logic [15:0] c_wd,
                         input logic d_req, input logic d_we,
                         input logic [7:0] d_addr, input logic [15:0] d_wd);
        @(posedge clk);
        #1;
        rst       = r;
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wd;
        dbg_req   = d_req;
        dbg_we    = d_we;
        dbg_addr  = d_addr;
        dbg_wdata = d_wd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] sum;

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

        // Reset state, with both ports requesting throughout.
        drive(1'b1, 1'b1, 1'b1, 8'd3, 16'h0000, 1'b1, 1'b0, 8'd0, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 8'd3, 16'h0000, 1'b1, 1'b0, 8'd0, 16'h0000);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_dbg_ack", dbg_ack, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        chk("rst_state", dbg_state, 0);

        // CPU only: write 0x1234 to addr 3, read it back.
        drive(1'b0, 1'b1, 1'b1, 8'd3, 16'h1234, 1'b0, 1'b0, 8'd0, 16'h0000);
        chk("cpu_wr_stall", cpu_stall, 0);
        chk("cpu_wr_en", mem_en, 1);
        chk("cpu_wr_we", mem_we, 1);
        chk("cpu_wr_addr", mem_addr, 3);
        chk("cpu_wr_data", mem_wdata, 16'h1234);
        drive(1'b0, 1'b1, 1'b0, 8'd3, 16'h0000, 1'b0, 1'b0, 8'd0, 16'h0000);
        chk("cpu_rd_stall", cpu_stall, 0);
        chk("cpu_rd_en", mem_en, 1);
        chk("cpu_rd_we", mem_we, 0);
        idle();
        chk("cpu_rdata", cpu_rdata, 16'h1234);
        chk("none_mem_en", mem_en, 0);
        chk("none_stall", cpu_stall, 0);

        // Debug only: write 0xBEEF to addr 0, read it back.
        drive(1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b1, 8'd0, 16'hBEEF);
        chk("dbg_wr_en", mem_en, 1);
        chk("dbg_wr_we", mem_we, 1);
        chk("dbg_wr_addr", mem_addr, 0);
        chk("dbg_wr_data", mem_wdata, 16'hBEEF);
        chk("dbg_wr_ack_early", dbg_ack, 0);
        idle();
        chk("dbg_wr_ack", dbg_ack, 1);
        chk("dbg_wr_state", dbg_state, 1);
        chk("dbg_wr_ack_noacc", mem_en, 0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 8'd0, 16'h0000);
        chk("dbg_wr_ack_pulse", dbg_ack, 0);
        chk("dbg_rd_en", mem_en, 1);
        chk("dbg_rd_we", mem_we, 0);
        idle();
        chk("dbg_rd_ack", dbg_ack, 1);
        idle();
        chk("dbg_rd_ack_pulse", dbg_ack, 0);
        chk("dbg_rdata_beef", dbg_rdata, 16'hBEEF);

        // Starvation: CPU reads addr 5 continuously, debug writes 0x0777 to addr 7.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'd5, 16'h0000, 1'b1, 1'b1, 8'd7, 16'h0777);
            chk($sformatf("starve_stall_%0d", i), cpu_stall, (i == 5));
            chk($sformatf("starve_addr_%0d", i), mem_addr, (i == 5) ? 8'd7 : 8'd5);
        end
        drive(1'b0, 1'b1, 1'b0, 8'd5, 16'h0000, 1'b0, 1'b0, 8'd0, 16'h0000);
        chk("starve_ack", dbg_ack, 1);
        chk("starve_ack_stall", cpu_stall, 0);
        chk("starve_ack_addr", mem_addr, 5);
        idle();
        chk("dbg_wr_keeps_rdata", dbg_rdata, 16'hBEEF);

        // Withdrawn debug request clears the starvation count.
        for (int i = 1; i <= 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'd5, 16'h0000, 1'b1, 1'b0, 8'd7, 16'h0000);
            chk($sformatf("drop_pre_stall_%0d", i), cpu_stall, 0);
        end
        drive(1'b0, 1'b1, 1'b0, 8'd5, 16'h0000, 1'b0, 1'b0, 8'd7, 16'h0000);
        chk("drop_ack", dbg_ack, 0);
        chk("drop_addr", mem_addr, 5);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'd5, 16'h0000, 1'b1, 1'b0, 8'd7, 16'h0000);
            chk($sformatf("drop_post_stall_%0d", i), cpu_stall, (i == 5));
            chk($sformatf("drop_post_ack_%0d", i), dbg_ack, 0);
        end
        drive(1'b0, 1'b1, 1'b0, 8'd5, 16'h0000, 1'b0, 1'b0, 8'd0, 16'h0000);
        chk("drop_final_ack", dbg_ack, 1);
        idle();
        chk("dbg_rdata_0777", dbg_rdata, 16'h0777);

        // dbg_req held across ack: one access every other cycle, none in ack cycles.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 8'd0, 16'h0000);
            chk($sformatf("held_en_%0d", i), mem_en, (i % 2 == 0));
            chk($sformatf("held_ack_%0d", i), dbg_ack, (i % 2 == 1));
        end
        idle();
        chk("held_end_en", mem_en, 0);
        chk("held_end_ack", dbg_ack, 0);
        chk("held_rdata", dbg_rdata, 16'hBEEF);

        // Write on one port, read on the other, both directions.
        drive(1'b0, 1'b1, 1'b1, 8'd10, 16'h5A5A, 1'b0, 1'b0, 8'd0, 16'h0000);
        chk("x_cpu_wr_we", mem_we, 1);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 8'd10, 16'h0000);
        chk("x_dbg_rd_addr", mem_addr, 10);
        idle();
        chk("x_dbg_rd_ack", dbg_ack, 1);
        idle();
        chk("x_dbg_rdata", dbg_rdata, 16'h5A5A);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b1, 8'd11, 16'hC3C3);
        chk("x_dbg_wr_we", mem_we, 1);
        drive(1'b0, 1'b1, 1'b0, 8'd11, 16'h0000, 1'b0, 1'b0, 8'd0, 16'h0000);
        chk("x_cpu_rd_ack", dbg_ack, 1);
        chk("x_cpu_rd_stall", cpu_stall, 0);
        chk("x_cpu_rd_addr", mem_addr, 11);
        chk("x_cpu_rd_we", mem_we, 0);
        idle();
        chk("x_cpu_rdata", cpu_rdata, 16'hC3C3);

        // Reset pulsed in the ack cycle of a pending debug read.
        drive(1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 8'd0, 16'h0000);
        chk("rack_grant_en", mem_en, 1);
        drive(1'b1, 1'b1, 1'b1, 8'd20, 16'h0000, 1'b0, 1'b0, 8'd0, 16'h0000);
        chk("rack_ack", dbg_ack, 0);
        chk("rack_en", mem_en, 0);
        chk("rack_stall", cpu_stall, 0);
        chk("rack_rdata", dbg_rdata, 0);
        drive(1'b1, 1'b1, 1'b1, 8'd20, 16'h0000, 1'b0, 1'b0, 8'd0, 16'h0000);
        chk("rack2_ack", dbg_ack, 0);
        chk("rack2_state", dbg_state, 0);
        chk("rack2_en", mem_en, 0);
        drive(1'b0, 1'b1, 1'b1, 8'd20, 16'h0042, 1'b1, 1'b0, 8'd0, 16'h0000);
        chk("post_rst_en", mem_en, 1);
        chk("post_rst_addr", mem_addr, 20);
        chk("post_rst_stall", cpu_stall, 0);
        chk("post_rst_ack", dbg_ack, 0);
        chk("post_rst_rdata", dbg_rdata, 0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 8'd20, 16'h0000);
        chk("post_rst_dbg_en", mem_en, 1);
        idle();
        chk("post_rst_dbg_ack", dbg_ack, 1);
        idle();
        chk("post_rst_dbg_rdata", dbg_rdata, 16'h0042);

        // Loader fills addr 0..1, CPU program stores their sum to addr 2.
        for (int k = 0; k < 64; k++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            drive(1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b1, 8'd0, a);
            idle();
            drive(1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b1, 8'd1, b);
            idle();
            drive(1'b0, 1'b1, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0, 8'd0, 16'h0000);
            drive(1'b0, 1'b1, 1'b0, 8'd1, 16'h0000, 1'b0, 1'b0, 8'd0, 16'h0000);
            ra = cpu_rdata;
            idle();
            rb = cpu_rdata;
            sum = ra + rb;
            drive(1'b0, 1'b1, 1'b1, 8'd2, sum, 1'b0, 1'b0, 8'd0, 16'h0000);
            idle();
            chk($sformatf("sum_%0d", k), mem_model[2], 16'(a + b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
